// File: rtl/as_gpio_ctrl_if.sv
// Peripheral bus bundle for as_gpio_ctrl: single-cycle request, registered
// completion one clock later.
interface as_gpio_ctrl_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 64
);
  logic              sel_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ack_o;

  modport master (
    output sel_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  sel_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o
  );
endinterface

// File: rtl/as_gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/output registers, synchronised
// input readback and edge-triggered W1C interrupt status.
module as_gpio_ctrl #(
  parameter int unsigned NR_GPIOS    = 8,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned ID_VALUE    = 129,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  as_gpio_ctrl_if.slave       bus,
  inout  wire  [NR_GPIOS-1:0] gpio_io,
  output logic                cs_o,
  output logic                irq_o
);

  localparam int unsigned         GUARD_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [GUARD_W-1:0]  GUARD_INIT = GUARD_W'(SYNC_STAGES + 1);
  localparam logic [DATA_W-1:0]   FIELD_MASK = DATA_W'({NR_GPIOS{1'b1}});

  typedef enum logic [ADDR_W-1:0] {
    REG_ID       = ADDR_W'(0),
    REG_DIR      = ADDR_W'(1),
    REG_OUT      = ADDR_W'(2),
    REG_IN       = ADDR_W'(3),
    REG_IRQ_EN   = ADDR_W'(4),
    REG_IRQ_MODE = ADDR_W'(5),
    REG_STAT     = ADDR_W'(6)
  } reg_addr_e;

  // Registers are held at bus width with upper bits masked to zero on write,
  // so reads zero-extend naturally and the constant flops fold away.
  logic [DATA_W-1:0]   dir_q, dir_d, out_q, out_d;
  logic [DATA_W-1:0]   irq_en_q, irq_en_d, irq_mode_q, irq_mode_d;
  logic [DATA_W-1:0]   stat_q, stat_d, rdata_q, rdata_d;
  logic                ack_q, ack_d, cs_q, cs_d, irq_q, irq_d;
  logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
  logic [NR_GPIOS-1:0] sync_d [SYNC_STAGES];
  logic [NR_GPIOS-1:0] dly_q, dly_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;

  logic                wr_en, rd_en;
  logic [DATA_W-1:0]   wdata_f;
  logic [NR_GPIOS-1:0] pin_in, sync_last, rise, fall, edge_hit, set_mask;

  assign pin_in    = gpio_io;
  assign sync_last = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pin
    assign gpio_io[g] = dir_q[g] ? out_q[g] : 1'bz;
  end

  always_comb begin
    wr_en   = bus.sel_i & bus.we_i;
    rd_en   = bus.sel_i & ~bus.we_i;
    wdata_f = bus.wdata_i & FIELD_MASK;

    sync_d[0] = pin_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    dly_d = sync_last;

    rise     = sync_last & ~dly_q;
    fall     = ~sync_last & dly_q;
    edge_hit = (rise & ~irq_mode_q[NR_GPIOS-1:0]) | (fall & irq_mode_q[NR_GPIOS-1:0]);
    set_mask = (guard_q == '0) ? (edge_hit & ~dir_q[NR_GPIOS-1:0]) : '0;
    guard_d  = (guard_q == '0) ? guard_q : guard_q - 1'b1;

    dir_d      = dir_q;
    out_d      = out_q;
    irq_en_d   = irq_en_q;
    irq_mode_d = irq_mode_q;
    stat_d     = stat_q;
    if (wr_en) begin
      case (bus.addr_i)
        REG_DIR:      dir_d      = wdata_f;
        REG_OUT:      out_d      = wdata_f;
        REG_IRQ_EN:   irq_en_d   = wdata_f;
        REG_IRQ_MODE: irq_mode_d = wdata_f;
        REG_STAT:     stat_d     = stat_q & ~wdata_f;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a simultaneous set survives.
    stat_d = stat_d | DATA_W'(set_mask);

    rdata_d = '0;
    if (rd_en) begin
      case (bus.addr_i)
        REG_ID:       rdata_d = DATA_W'(ID_VALUE);
        REG_DIR:      rdata_d = dir_q;
        REG_OUT:      rdata_d = out_q;
        REG_IN:       rdata_d = DATA_W'(sync_last);
        REG_IRQ_EN:   rdata_d = irq_en_q;
        REG_IRQ_MODE: rdata_d = irq_mode_q;
        REG_STAT:     rdata_d = stat_q;
        default:      rdata_d = '0;
      endcase
    end

    ack_d = bus.sel_i;
    cs_d  = wr_en && (bus.addr_i == REG_OUT);
    irq_d = |(stat_q & irq_en_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dir_q      <= '0;
      out_q      <= '0;
      irq_en_q   <= '0;
      irq_mode_q <= '0;
      stat_q     <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      cs_q       <= 1'b0;
      irq_q      <= 1'b0;
      sync_q     <= '{default: '0};
      dly_q      <= '0;
      guard_q    <= GUARD_INIT;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      irq_en_q   <= irq_en_d;
      irq_mode_q <= irq_mode_d;
      stat_q     <= stat_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      cs_q       <= cs_d;
      irq_q      <= irq_d;
      sync_q     <= sync_d;
      dly_q      <= dly_d;
      guard_q    <= guard_d;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack_q;
  assign cs_o        = cs_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Directed bench for as_gpio_ctrl: bus responses checked through an
// expectation queue, pin/irq behaviour checked at fixed points.
module tb_as_gpio_ctrl;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        cs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs, irq;
  wire  [7:0] gpio;
  logic [7:0] tb_en, tb_val;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  exp_t        sb_q[$];

  as_gpio_ctrl_if #(.ADDR_W(3), .DATA_W(64)) bus ();

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign gpio[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  as_gpio_ctrl #(
    .NR_GPIOS(8), .DATA_W(64), .ADDR_W(3), .ID_VALUE(129), .SYNC_STAGES(2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .gpio_io(gpio),
    .cs_o   (cs),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rd, input string tag);
    exp_t e;
    e.tag   = tag;
    e.rdata = exp_rd;
    e.cs    = we && (addr == 3'd2);
    sb_q.push_back(e);
    bus.sel_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
  endtask

  task automatic collect();
    exp_t e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_empty: observed=0 expected=1 pending entries");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_ack"},   64'(bus.ack_o), 64'd1);
      chk({e.tag, "_rdata"}, bus.rdata_o,    e.rdata);
      chk({e.tag, "_cs"},    64'(cs),        64'(e.cs));
    end
  endtask

  task automatic idle();
    bus.sel_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic acc(input logic we, input logic [2:0] addr, input logic [63:0] wdata,
                     input logic [63:0] exp_rd, input string tag);
    @(negedge clk);
    issue(we, addr, wdata, exp_rd, tag);
    collect();
    idle();
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    bus.sel_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    tb_en       = 8'hFF;
    tb_val      = 8'h80;

    // Reset with pin 7 held high
    tick(3); #1;
    chk("rst_ack",   64'(bus.ack_o), 64'd0);
    chk("rst_rdata", bus.rdata_o,    64'd0);
    chk("rst_cs",    64'(cs),        64'd0);
    chk("rst_irq",   64'(irq),       64'd0);
    @(negedge clk); rst = 1'b1;
    tick(6);
    acc(1'b0, 3'd6, '0, 64'h00, "guard_stat");
    acc(1'b0, 3'd3, '0, 64'h80, "guard_in");

    // ID and unmapped / read-only handling
    acc(1'b0, 3'd0, '0, 64'h81, "id");
    acc(1'b0, 3'd7, '0, 64'h00, "unmapped_rd");
    acc(1'b1, 3'd0, 64'h55, 64'h00, "id_wr");
    acc(1'b1, 3'd7, 64'h55, 64'h00, "unmapped_wr");
    acc(1'b0, 3'd0, '0, 64'h81, "id_again");

    // Falling edge in rising mode must not set STAT
    @(negedge clk); tb_val = 8'h00;
    tick(4);
    acc(1'b0, 3'd6, '0, 64'h00, "fall_in_rise_mode");

    // Output drive
    tb_en = 8'hF0;
    acc(1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FF0F, 64'h00, "dir_wr");
    @(negedge clk); issue(1'b0, 3'd1, '0, 64'h0F, "dir_b2b");
    collect();
    @(negedge clk); issue(1'b0, 3'd0, '0, 64'h81, "id_b2b");
    collect();
    idle();
    acc(1'b1, 3'd2, 64'hA5, 64'h00, "out_wr");
    chk("pins_lo", 64'(gpio[3:0]), 64'h5);
    @(posedge clk); #1;
    chk("cs_one_cycle", 64'(cs), 64'd0);
    @(negedge clk); tb_val = 8'hC0;
    tick(4);
    acc(1'b0, 3'd3, '0, 64'hC5, "in_mixed");
    acc(1'b0, 3'd2, '0, 64'hA5, "out_rd");
    acc(1'b0, 3'd6, '0, 64'hC0, "stat_unmasked");
    chk("irq_masked", 64'(irq), 64'd0);
    acc(1'b1, 3'd6, 64'hFF, 64'h00, "stat_clr_all");
    acc(1'b0, 3'd6, '0, 64'h00, "stat_zero");

    // Input sync latency and rising interrupt
    tb_val = 8'h05;
    acc(1'b1, 3'd1, 64'h00, 64'h00, "dir_in");
    tb_en = 8'hFF;
    tick(4);
    acc(1'b1, 3'd4, 64'h80, 64'h00, "irq_en_wr");
    acc(1'b1, 3'd5, 64'h00, 64'h00, "irq_mode_rise");
    @(negedge clk); tb_val = 8'h00;
    tick(4);
    acc(1'b0, 3'd6, '0, 64'h00, "stat_quiet");
    @(negedge clk); tb_val = 8'h80;
    issue(1'b0, 3'd3, '0, 64'h00, "in_edge1");
    collect();
    @(negedge clk); issue(1'b0, 3'd3, '0, 64'h00, "in_edge2");
    collect();
    @(negedge clk); issue(1'b0, 3'd3, '0, 64'h80, "in_edge3");
    collect();
    @(negedge clk); issue(1'b0, 3'd6, '0, 64'h80, "stat_rise");
    collect();
    idle();
    chk("irq_set", 64'(irq), 64'd1);
    acc(1'b1, 3'd6, 64'h80, 64'h00, "stat_w1c");
    chk("irq_lag", 64'(irq), 64'd1);
    @(posedge clk); #1;
    chk("irq_clr", 64'(irq), 64'd0);
    acc(1'b0, 3'd6, '0, 64'h00, "stat_cleared");

    // Falling interrupt and set/clear collision
    acc(1'b1, 3'd5, 64'h01, 64'h00, "irq_mode_fall");
    @(negedge clk); tb_val = 8'h81;
    tick(4);
    @(negedge clk); tb_val = 8'h80;
    tick(4);
    acc(1'b0, 3'd6, '0, 64'h01, "stat_fall");
    chk("irq_fall_masked", 64'(irq), 64'd0);
    acc(1'b1, 3'd6, 64'h01, 64'h00, "stat_w1c0");
    acc(1'b0, 3'd6, '0, 64'h00, "stat_w1c0_rd");
    @(negedge clk); tb_val = 8'h81;
    tick(4);
    @(negedge clk); tb_val = 8'h80;
    tick(2);
    acc(1'b1, 3'd6, 64'h01, 64'h00, "collide_w1c");
    acc(1'b0, 3'd6, '0, 64'h01, "collide_stat");

    // Reset during an OUT write
    tb_en = 8'hF0;
    acc(1'b1, 3'd1, 64'h0F, 64'h00, "dir_pre_rst");
    @(negedge clk);
    rst         = 1'b0;
    bus.sel_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 3'd2;
    bus.wdata_i = 64'hFF;
    @(posedge clk); #1;
    chk("midrst_ack", 64'(bus.ack_o), 64'd0);
    chk("midrst_cs",  64'(cs),        64'd0);
    idle();
    tb_en  = 8'hFF;
    tb_val = 8'h0A;
    @(negedge clk); rst = 1'b1;
    tick(5);
    acc(1'b0, 3'd3, '0, 64'h0A, "midrst_in");
    acc(1'b0, 3'd2, '0, 64'h00, "midrst_out");
    acc(1'b0, 3'd1, '0, 64'h00, "midrst_dir");
    acc(1'b0, 3'd6, '0, 64'h00, "midrst_guard");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
